// File: rtl/calc_seq_pkg.sv
// Shared constants for the sequential calculator: function codes and FSM state encoding.
package calc_seq_pkg;

  localparam logic [2:0] FN_ADD = 3'b000;
  localparam logic [2:0] FN_SUB = 3'b001;
  localparam logic [2:0] FN_AND = 3'b010;
  localparam logic [2:0] FN_OR  = 3'b011;
  localparam logic [2:0] FN_SHL = 3'b100;
  localparam logic [2:0] FN_MUL = 3'b101;
  localparam logic [2:0] FN_DIV = 3'b110;
  localparam logic [2:0] FN_ACC = 3'b111;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIN  = 2'd2;

endpackage

// File: rtl/calc_seq_debounce.sv
// Push-button conditioner: 2-FF synchroniser, counter debounce, and a one-cycle
// start pulse on each accepted 0->1 transition of the debounced level.
module calc_seq_debounce #(
  parameter int DEBOUNCE_CYC = 20000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic start
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic             start_q, start_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Level flips on the DEBOUNCE_CYC-th consecutive cycle of disagreement.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    start_d = 1'b0;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d   = '0;
      level_d = sync2_q;
      start_d = sync2_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Synchroniser and debounce state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      start_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_in;
      sync2_q <= sync1_q;
      level_q <= level_d;
      start_q <= start_d;
      cnt_q   <= cnt_d;
    end
  end

  assign start = start_q;

endmodule

// File: rtl/calc_seq_unit.sv
// Sequential hex calculator: button-triggered ALU, shift-add multiply, accumulate.
// Define CALC_DIV_EN to build the restoring divider; otherwise DIV reports an error.
module calc_seq_unit
  import calc_seq_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int RES_W        = 32,
  parameter int DEBOUNCE_CYC = 20000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              locked,
  input  logic              button,
  input  logic [2:0]        func,
  input  logic [DATA_W-1:0] num1,
  input  logic [DATA_W-1:0] num2,
  output logic [RES_W-1:0]  cal_result,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam int SH_W  = $clog2(RES_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  logic              rst_s, start_s, iter_s, alu_err_s;
  logic [1:0]        state_q, state_d;
  logic [2:0]        func_q, func_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [RES_W-1:0]  work_q, work_d, mcand_q, mcand_d, res_q, res_d;
  logic              busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [RES_W-1:0]  a_ext_s, b_ext_s, alu_res_s, iter_res_s;
  logic [RES_W:0]    acc_sum_s;
`ifdef CALC_DIV_EN
  logic [DATA_W-1:0] rem_q, rem_d;
  logic [DATA_W:0]   rem_sh_s, rem_diff_s;
`endif

  assign rst_s = rst | ~locked;

  calc_seq_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_debounce (
    .clk    (clk),
    .rst    (rst_s),
    .btn_in (button),
    .start  (start_s)
  );

  assign a_ext_s   = RES_W'(a_q);
  assign b_ext_s   = RES_W'(b_q);
  assign acc_sum_s = {1'b0, res_q} + {1'b0, a_ext_s};

`ifdef CALC_DIV_EN
  // A zero divisor short-circuits to the single-cycle error path.
  assign iter_s     = (func_q == FN_MUL) || ((func_q == FN_DIV) && (b_q != '0));
  assign rem_sh_s   = {rem_q, a_q[DATA_W-1]};
  assign rem_diff_s = rem_sh_s - {1'b0, b_q};
  assign iter_res_s = (func_q == FN_DIV) ? ((RES_W'(rem_q) << (RES_W / 2)) | a_ext_s) : work_q;
`else
  assign iter_s     = (func_q == FN_MUL);
  assign iter_res_s = work_q;
`endif

  // Single-cycle result and error for the latched function.
  always_comb begin
    alu_res_s = '0;
    alu_err_s = 1'b0;
    case (func_q)
      FN_ADD: alu_res_s = a_ext_s + b_ext_s;
      FN_SUB: alu_res_s = a_ext_s - b_ext_s;
      FN_AND: alu_res_s = a_ext_s & b_ext_s;
      FN_OR:  alu_res_s = a_ext_s | b_ext_s;
      FN_SHL: alu_res_s = a_ext_s << b_ext_s[SH_W-1:0];
      FN_ACC: begin
        alu_res_s = acc_sum_s[RES_W-1:0];
        alu_err_s = acc_sum_s[RES_W];
      end
`ifdef CALC_DIV_EN
      FN_DIV: begin
        alu_res_s = '1;
        alu_err_s = 1'b1;
      end
`else
      FN_DIV: begin
        alu_res_s = '0;
        alu_err_s = 1'b1;
      end
`endif
      default: alu_res_s = '0;
    endcase
  end

  // Control FSM and iterative datapath next-state.
  always_comb begin
    state_d = state_q;
    func_d  = func_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    mcand_d = mcand_q;
    res_d   = res_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;
`ifdef CALC_DIV_EN
    rem_d   = rem_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start_s) begin
          state_d = ST_RUN;
          func_d  = func;
          a_d     = num1;
          b_d     = num2;
          cnt_d   = '0;
          work_d  = '0;
          mcand_d = RES_W'(num1);
          busy_d  = 1'b1;
          err_d   = 1'b0;
`ifdef CALC_DIV_EN
          rem_d   = '0;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (iter_s) begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = (cnt_q == CNT_LAST) ? ST_FIN : ST_RUN;
          work_d  = b_q[0] ? (work_q + mcand_q) : work_q;
          mcand_d = mcand_q << 1;
          b_d     = b_q >> 1;
`ifdef CALC_DIV_EN
          if (func_q == FN_DIV) begin
            work_d  = work_q;
            mcand_d = mcand_q;
            b_d     = b_q;
            a_d     = {a_q[DATA_W-2:0], ~rem_diff_s[DATA_W]};
            rem_d   = rem_diff_s[DATA_W] ? rem_sh_s[DATA_W-1:0] : rem_diff_s[DATA_W-1:0];
          end else begin
            rem_d   = rem_q;
          end
`endif
        end else begin
          // Single-cycle ops land their result on entry to FIN.
          state_d = ST_FIN;
          res_d   = alu_res_s;
          err_d   = alu_err_s;
          done_d  = 1'b1;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        if (iter_s) begin
          res_d  = iter_res_s;
          done_d = 1'b1;
        end else begin
          res_d  = res_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; lock loss behaves as reset.
  always_ff @(posedge clk) begin
    if (rst_s) begin
      state_q <= ST_IDLE;
      func_q  <= FN_ADD;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      work_q  <= '0;
      mcand_q <= '0;
      res_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef CALC_DIV_EN
      rem_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      func_q  <= func_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      mcand_q <= mcand_d;
      res_q   <= res_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef CALC_DIV_EN
      rem_q   <= rem_d;
`endif
    end
  end

  assign cal_result = res_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_calc_seq_unit.sv
// Directed bench for calc_seq_unit (DATA_W=8, RES_W=32, DEBOUNCE_CYC=4).
module tb_calc_seq_unit;
  import calc_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst, locked, button;
  logic [2:0]  func;
  logic [7:0]  num1, num2;
  logic [31:0] cal_result;
  logic        busy, done, err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  calc_seq_unit #(.DATA_W(8), .RES_W(32), .DEBOUNCE_CYC(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .locked     (locked),
    .button     (button),
    .func       (func),
    .num1       (num1),
    .num2       (num2),
    .cal_result (cal_result),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Press the button, release after 4 cycles, optionally re-press while busy, and
  // observe a fixed 40-cycle window.
  task automatic run_op(input string tag, input logic [2:0] f, input logic [7:0] a,
                        input logic [7:0] b, input logic [31:0] exp_res, input logic exp_err,
                        input int exp_lat, input int exp_busy, input bit repress);
    int          lat, busy_cnt, n_done;
    bit          got;
    logic [31:0] res_seen;
    logic        err_seen;
    lat = 0; busy_cnt = 0; n_done = 0; got = 1'b0; res_seen = 32'h0; err_seen = 1'b0;
    @(negedge clk);
    func = f; num1 = a; num2 = b; button = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (!got && busy) busy_cnt++;
      if (done) begin
        n_done++;
        if (!got) begin
          got = 1'b1; lat = n; res_seen = cal_result; err_seen = err;
        end
      end
      if (n == 4) button = 1'b0;
      if (repress && n == 9) button = 1'b1;
      if (repress && n == 20) button = 1'b0;
    end
    check_eq({tag, "_lat"}, lat, exp_lat);
    check_eq({tag, "_res"}, res_seen, exp_res);
    check_eq({tag, "_err"}, {31'd0, err_seen}, {31'd0, exp_err});
    check_eq({tag, "_busy"}, busy_cnt, exp_busy);
    check_eq({tag, "_ndone"}, n_done, 1);
  endtask

  task automatic pulse_reset();
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int dones, bad;
    rst = 1'b1; locked = 1'b1; button = 1'b0; func = FN_ADD; num1 = 8'h00; num2 = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_result", cal_result, 32'h0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_done", {31'd0, done}, 32'd0);
    check_eq("rst_err", {31'd0, err}, 32'd0);

    // Two-cycle glitch must not start anything.
    func = FN_ADD; num1 = 8'h01; num2 = 8'h02;
    button = 1'b1;
    repeat (2) @(negedge clk);
    button = 1'b0;
    dones = 0;
    repeat (20) begin @(negedge clk); if (done) dones++; end
    check_eq("glitch_ndone", dones, 0);
    check_eq("glitch_result", cal_result, 32'h0);

    // Ten-cycle hold gives exactly one operation.
    button = 1'b1; dones = 0;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (done) dones++;
      if (n == 10) button = 1'b0;
    end
    check_eq("hold_ndone", dones, 1);
    check_eq("hold_result", cal_result, 32'h3);

    run_op("add", FN_ADD, 8'h12, 8'h34, 32'h00000046, 1'b0, 8, 2, 1'b0);
    run_op("sub", FN_SUB, 8'h05, 8'h07, 32'hFFFFFFFE, 1'b0, 8, 2, 1'b0);
    run_op("and", FN_AND, 8'hF0, 8'h3C, 32'h00000030, 1'b0, 8, 2, 1'b0);
    run_op("or",  FN_OR,  8'hF0, 8'h3C, 32'h000000FC, 1'b0, 8, 2, 1'b0);
    run_op("shl_wrap", FN_SHL, 8'h81, 8'h1C, 32'h10000000, 1'b0, 8, 2, 1'b0);
    run_op("shl_mask", FN_SHL, 8'h81, 8'h25, 32'h00001020, 1'b0, 8, 2, 1'b0);
    run_op("mul", FN_MUL, 8'hFF, 8'hFF, 32'h0000FE01, 1'b0, 16, 9, 1'b1);

`ifdef CALC_DIV_EN
    run_op("div", FN_DIV, 8'h64, 8'h07, 32'h0002000E, 1'b0, 16, 9, 1'b0);
    run_op("div0", FN_DIV, 8'h10, 8'h00, 32'hFFFFFFFF, 1'b1, 8, 2, 1'b0);
`else
    run_op("div", FN_DIV, 8'h64, 8'h07, 32'h00000000, 1'b1, 8, 2, 1'b0);
    run_op("div0", FN_DIV, 8'h10, 8'h00, 32'h00000000, 1'b1, 8, 2, 1'b0);
`endif
    run_op("add_clr", FN_ADD, 8'h01, 8'h01, 32'h00000002, 1'b0, 8, 2, 1'b0);

    pulse_reset();
    run_op("acc1", FN_ACC, 8'h80, 8'h00, 32'h00000080, 1'b0, 8, 2, 1'b0);
    run_op("acc2", FN_ACC, 8'h80, 8'h00, 32'h00000100, 1'b0, 8, 2, 1'b0);
    run_op("preload", FN_SUB, 8'h00, 8'h10, 32'hFFFFFFF0, 1'b0, 8, 2, 1'b0);
    run_op("acc_ovf", FN_ACC, 8'h20, 8'h00, 32'h00000010, 1'b1, 8, 2, 1'b0);

    // Reset in the middle of a multiply discards it.
    @(negedge clk);
    func = FN_MUL; num1 = 8'h03; num2 = 8'h05; button = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (n == 4) button = 1'b0;
    end
    check_eq("mid_busy_before", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_result", cal_result, 32'h0);
    check_eq("mid_rst_busy", {31'd0, busy}, 32'd0);
    check_eq("mid_rst_done", {31'd0, done}, 32'd0);
    rst = 1'b0; dones = 0;
    repeat (30) begin @(negedge clk); if (done) dones++; end
    check_eq("mid_rst_ndone", dones, 0);

    // Lock loss holds every output at its reset value, even with the button held.
    run_op("pre_lock", FN_SUB, 8'h00, 8'h10, 32'hFFFFFFF0, 1'b0, 8, 2, 1'b0);
    run_op("pre_lock_acc", FN_ACC, 8'h20, 8'h00, 32'h00000010, 1'b1, 8, 2, 1'b0);
    @(negedge clk);
    locked = 1'b0; button = 1'b1; bad = 0;
    for (int n = 1; n <= 15; n++) begin
      @(negedge clk);
      if (cal_result !== 32'h0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) bad++;
      if (n == 12) button = 1'b0;
    end
    check_eq("lock_hold", bad, 0);
    locked = 1'b1; dones = 0;
    repeat (20) begin @(negedge clk); if (done) dones++; end
    check_eq("lock_release_ndone", dones, 0);
    check_eq("lock_release_result", cal_result, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
